alu_md_seq: RTL and testbench
=============================

// Module: alu_md_seq
// PURPOSE
//  Parametrised, handshaked ALU for the cpu_core datapath. Keeps the existing single-cycle op set.
//  Adds iterative multiply/divide. Every op goes through a valid/ready pipeline slot with a registered result.
//  Sits between the ID/EX issue logic and the WB stage. The EX stage stalls on in_ready/out_valid.
// PARAMETERS
//  WIDTH    32  operand/result width; power of 2, >=8; shift amount = B[$clog2(WIDTH)-1:0]
//  MD_EN    1   1: M ops iterate; 0: M ops complete in 1 cycle with Result=0, flags 0
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset: asynchronous, active-high
//  flush      in   1      synchronous abort: drop in-flight op, return to IDLE
//  in_valid   in   1      operands/op valid
//  in_ready   out  1      block can accept (state==IDLE)
//  A, B       in   WIDTH  operands
//  ALUop      in   5      op code (below)
//  out_valid  out  1      Result/flags valid
//  out_ready  in   1      consumer takes result
//  Result     out  WIDTH  registered result
//  Overflow   out  1      signed overflow; ADD/SUB only, else 0
//  CarryOut   out  1      ADD: carry out; SUB: borrow (~carry); else 0
//  Zero       out  1      Result==0, for every op
// BEHAVIOUR
//  Op codes, 1-cycle class (same semantics as existing ALU, generalised to WIDTH):
//   ADD 00000, SUB 00001, SLT 01000, SLTU 01001, SNE 01010, SE 01011, SGE 01100, SGEU 01101
//   SLL 10000, SRL 10001, SRA 10010, AND 10100, OR 10101, XOR 10110, NOR 10111
//   BYPASS 11000 (Result=B), JLINK 11001 (Result=A+4)
//   Compare ops: Result = {WIDTH-1 zeros, bit}
//  Multi-cycle class: MUL 00100 (low half, signed), MULH 00101 (high, s*s), MULHU 00110 (high, u*u)
//   DIV 11100, DIVU 11101, REM 11110, REMU 11111
//  Undefined op codes: 1-cycle, Result=0, flags 0
//  FSM IDLE -> (BUSY) -> DONE -> IDLE
//   IDLE: in_ready=1. Accept on in_valid&&in_ready; latch A, B, ALUop.
//         1-cycle op: compute, go to DONE. M op (MD_EN=1): go to BUSY, cnt=0.
//   BUSY: in_ready=0. Radix-2 shift-add (mul) or restoring shift-subtract (div) on magnitudes.
//         One bit per cycle, cnt++; at cnt==WIDTH-1, apply sign fixup, load Result, go to DONE.
//   DONE: out_valid=1. On out_ready, go to IDLE. Result/flags held stable while out_ready=0.
//  Latency, accept edge to out_valid: 1 cycle for 1-cycle ops, WIDTH+1 cycles for M ops.
//  Throughput: one op per 2 cycles minimum. No accept while DONE; no bypass of the DONE slot.
//  Signed div/rem: quotient truncates toward zero; remainder takes the dividend's sign.
//  Divide by zero (B==0): quotient all ones; remainder = A. Same latency as a normal divide.
//  Overflow case (A=signed min, B=-1, DIV/REM): quotient=A, remainder=0, Overflow stays 0.
//  Products: full 2*WIDTH internal; MUL returns [WIDTH-1:0], MULH/MULHU return [2W-1:W].
//  flush: any state -> IDLE next cycle; out_valid drops; dropped result is never presented.
//   flush has priority over a same-cycle accept (op not taken) and over out_ready.
//  rst: all state cleared immediately. state=IDLE, cnt=0, out_valid=0, Result=0, Overflow/CarryOut/Zero=0.
//   in_ready=0 while rst is high, 1 the first cycle after release. Reset mid-BUSY discards the op.
// TESTING
//  ADD A=32'h7FFFFFFF B=1 -> 1 cycle later out_valid, Result=32'h80000000, Overflow=1, CarryOut=0, Zero=0
//  SUB A=B=5, then SLTU A=1 B=2 (back-to-back, out_ready=1)
//   -> Result 0 with Zero=1, CarryOut=0; then Result 1
//  MULH A=32'hFFFFFFFF B=2 -> out_valid exactly 33 cycles after accept, Result=32'hFFFFFFFF; MULHU same -> 1
//  DIV A=-7 B=2 -> -3; REM -> -1; DIVU A=9 B=0 -> 32'hFFFFFFFF; REMU -> 9; DIV 32'h80000000/-1 -> 32'h80000000
//  Backpressure: hold out_ready=0 for 10 cycles on a DIV -> Result stable, in_ready=0 throughout
//  flush at BUSY cycle 7 of a DIV with in_valid=1 -> IDLE next cycle, no out_valid, new op not taken
//  rst pulse mid-BUSY -> all outputs 0 immediately; next op after release completes normally
//  Repeat the ADD and DIV cases with WIDTH=16

Source files
------------

// File: rtl/alu_md_seq_if.sv
// Issue/writeback handshake bundle for alu_md_seq: operands and op code in,
// registered result and flags out, each side with its own valid/ready pair.
interface alu_md_seq_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [4:0]       alu_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             overflow;
   logic             carry_out;
   logic             zero;

   modport master (
      output in_valid, a, b, alu_op, out_ready,
      input  in_ready, out_valid, result, overflow, carry_out, zero
   );

   modport slave (
      input  in_valid, a, b, alu_op, out_ready,
      output in_ready, out_valid, result, overflow, carry_out, zero
   );
endinterface

// File: rtl/alu_md_seq.sv
// Handshaked ALU: 1-cycle ops appear one cycle after accept, iterative mul/div after WIDTH+1.
// The result slot holds until out_ready; nothing new is accepted while BUSY or DONE.
module alu_md_seq #(
   parameter int WIDTH = 32,
   parameter bit MD_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   alu_md_seq_if.slave bus
);
   localparam int CW  = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   localparam logic [4:0] OP_ADD    = 5'b00000;
   localparam logic [4:0] OP_SUB    = 5'b00001;
   localparam logic [4:0] OP_MUL    = 5'b00100;
   localparam logic [4:0] OP_MULH   = 5'b00101;
   localparam logic [4:0] OP_MULHU  = 5'b00110;
   localparam logic [4:0] OP_SLT    = 5'b01000;
   localparam logic [4:0] OP_SLTU   = 5'b01001;
   localparam logic [4:0] OP_SNE    = 5'b01010;
   localparam logic [4:0] OP_SE     = 5'b01011;
   localparam logic [4:0] OP_SGE    = 5'b01100;
   localparam logic [4:0] OP_SGEU   = 5'b01101;
   localparam logic [4:0] OP_SLL    = 5'b10000;
   localparam logic [4:0] OP_SRL    = 5'b10001;
   localparam logic [4:0] OP_SRA    = 5'b10010;
   localparam logic [4:0] OP_AND    = 5'b10100;
   localparam logic [4:0] OP_OR     = 5'b10101;
   localparam logic [4:0] OP_XOR    = 5'b10110;
   localparam logic [4:0] OP_NOR    = 5'b10111;
   localparam logic [4:0] OP_BYPASS = 5'b11000;
   localparam logic [4:0] OP_JLINK  = 5'b11001;
   localparam logic [4:0] OP_DIV    = 5'b11100;
   localparam logic [4:0] OP_DIVU   = 5'b11101;
   localparam logic [4:0] OP_REM    = 5'b11110;
   localparam logic [4:0] OP_REMU   = 5'b11111;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [4:0]       op_q;
   logic             mneg_q;
   logic             aneg_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] mc_q;
   logic [WIDTH-1:0] result_q;
   logic             ovf_q;
   logic             cout_q;
   logic             zero_q;

   function automatic logic is_mop(input logic [4:0] op);
      return op inside {OP_MUL, OP_MULH, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   // Single-cycle datapath, evaluated on the operands presented at accept.
   logic [WIDTH:0]   add_w;
   logic [WIDTH:0]   sub_w;
   logic [CW-1:0]    shamt;
   logic [WIDTH-1:0] alu_res_d;
   logic             alu_ovf_d;
   logic             alu_cout_d;

   always_comb begin
      add_w      = {1'b0, bus.a} + {1'b0, bus.b};
      sub_w      = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
      shamt      = bus.b[CW-1:0];
      alu_res_d  = '0;
      alu_ovf_d  = 1'b0;
      alu_cout_d = 1'b0;
      case (bus.alu_op)
         OP_ADD: begin
            alu_res_d  = add_w[WIDTH-1:0];
            alu_ovf_d  = (bus.a[MSB] == bus.b[MSB]) && (add_w[MSB] != bus.a[MSB]);
            alu_cout_d = add_w[WIDTH];
         end
         OP_SUB: begin
            alu_res_d  = sub_w[WIDTH-1:0];
            alu_ovf_d  = (bus.a[MSB] != bus.b[MSB]) && (sub_w[MSB] != bus.a[MSB]);
            alu_cout_d = ~sub_w[WIDTH];
         end
         OP_SLT:    alu_res_d[0] = $signed(bus.a) < $signed(bus.b);
         OP_SLTU:   alu_res_d[0] = bus.a < bus.b;
         OP_SNE:    alu_res_d[0] = bus.a != bus.b;
         OP_SE:     alu_res_d[0] = bus.a == bus.b;
         OP_SGE:    alu_res_d[0] = $signed(bus.a) >= $signed(bus.b);
         OP_SGEU:   alu_res_d[0] = bus.a >= bus.b;
         OP_SLL:    alu_res_d    = bus.a << shamt;
         OP_SRL:    alu_res_d    = bus.a >> shamt;
         OP_SRA:    alu_res_d    = $unsigned($signed(bus.a) >>> shamt);
         OP_AND:    alu_res_d    = bus.a & bus.b;
         OP_OR:     alu_res_d    = bus.a | bus.b;
         OP_XOR:    alu_res_d    = bus.a ^ bus.b;
         OP_NOR:    alu_res_d    = ~(bus.a | bus.b);
         OP_BYPASS: alu_res_d    = bus.b;
         OP_JLINK:  alu_res_d    = bus.a + WIDTH'(4);
         default:   alu_res_d    = '0;
      endcase
   end

   // Signed M ops iterate on magnitudes; the signs are kept for the final fixup.
   logic             sgn_op;
   logic             a_neg_d;
   logic             b_neg_d;
   logic [WIDTH-1:0] ma_d;
   logic [WIDTH-1:0] mb_d;

   always_comb begin
      sgn_op  = bus.alu_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
      a_neg_d = sgn_op && bus.a[MSB];
      b_neg_d = sgn_op && bus.b[MSB];
      ma_d    = a_neg_d ? -bus.a : bus.a;
      mb_d    = b_neg_d ? -bus.b : bus.b;
   end

   logic [WIDTH:0]     madd;
   logic [WIDTH:0]     rsh;
   logic [WIDTH+1:0]   dsub;
   logic               ge;
   logic [WIDTH-1:0]   hi_d;
   logic [WIDTH-1:0]   lo_d;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   md_res_d;
   logic               unused_dsub_bit;

   assign unused_dsub_bit = dsub[WIDTH];

   // hi/lo hold the partial product (mul) or the partial remainder and quotient (div).
   always_comb begin
      madd = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : {(WIDTH+1){1'b0}});
      rsh  = {hi_q, lo_q[MSB]};
      dsub = {1'b0, rsh} - {2'b00, mc_q};
      ge   = ~dsub[WIDTH+1];
      if (op_q[4]) begin
         hi_d = ge ? dsub[WIDTH-1:0] : rsh[WIDTH-1:0];
         lo_d = {lo_q[WIDTH-2:0], ge};
      end else begin
         hi_d = madd[WIDTH:1];
         lo_d = {madd[0], lo_q[WIDTH-1:1]};
      end
      prod = mneg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
      case (op_q)
         OP_MUL:             md_res_d = prod[WIDTH-1:0];
         OP_MULH, OP_MULHU:  md_res_d = prod[2*WIDTH-1:WIDTH];
         OP_DIV, OP_DIVU:    md_res_d = (mc_q == '0) ? '1 : (mneg_q ? -lo_d : lo_d);
         OP_REM, OP_REMU:    md_res_d = aneg_q ? -hi_d : hi_d;
         default:            md_res_d = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         mneg_q   <= 1'b0;
         aneg_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         mc_q     <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         cout_q   <= 1'b0;
         zero_q   <= 1'b0;
      end else if (flush) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  if (MD_EN && is_mop(bus.alu_op)) begin
                     state_q <= BUSY;
                     cnt_q   <= '0;
                     op_q    <= bus.alu_op;
                     mneg_q  <= a_neg_d ^ b_neg_d;
                     aneg_q  <= a_neg_d;
                     hi_q    <= '0;
                     lo_q    <= bus.alu_op[4] ? ma_d : mb_d;
                     mc_q    <= bus.alu_op[4] ? mb_d : ma_d;
                  end else begin
                     state_q  <= DONE;
                     result_q <= alu_res_d;
                     ovf_q    <= alu_ovf_d;
                     cout_q   <= alu_cout_d;
                     zero_q   <= (alu_res_d == '0);
                  end
               end
            end
            BUSY: begin
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_q  <= DONE;
                  result_q <= md_res_d;
                  ovf_q    <= 1'b0;
                  cout_q   <= 1'b0;
                  zero_q   <= (md_res_d == '0);
               end else begin
                  hi_q  <= hi_d;
                  lo_q  <= lo_d;
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == IDLE) && !rst;
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = result_q;
   assign bus.overflow  = ovf_q;
   assign bus.carry_out = cout_q;
   assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_md_seq.sv
// Directed bench for alu_md_seq at WIDTH=32 and WIDTH=16: op results, flags, latency,
// backpressure hold, flush and reset while an iterative op is in flight.
module tb_alu_md_seq;
   localparam logic [4:0] OP_ADD    = 5'b00000;
   localparam logic [4:0] OP_SUB    = 5'b00001;
   localparam logic [4:0] OP_MUL    = 5'b00100;
   localparam logic [4:0] OP_MULH   = 5'b00101;
   localparam logic [4:0] OP_MULHU  = 5'b00110;
   localparam logic [4:0] OP_SLT    = 5'b01000;
   localparam logic [4:0] OP_SLTU   = 5'b01001;
   localparam logic [4:0] OP_SGE    = 5'b01100;
   localparam logic [4:0] OP_SLL    = 5'b10000;
   localparam logic [4:0] OP_SRA    = 5'b10010;
   localparam logic [4:0] OP_NOR    = 5'b10111;
   localparam logic [4:0] OP_BYPASS = 5'b11000;
   localparam logic [4:0] OP_JLINK  = 5'b11001;
   localparam logic [4:0] OP_DIV    = 5'b11100;
   localparam logic [4:0] OP_DIVU   = 5'b11101;
   localparam logic [4:0] OP_REM    = 5'b11110;
   localparam logic [4:0] OP_REMU   = 5'b11111;
   localparam logic [4:0] OP_UNDEF  = 5'b00010;

   logic clk   = 1'b0;
   logic rst   = 1'b0;
   logic flush = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   alu_md_seq_if #(.WIDTH(32)) if32 ();
   alu_md_seq_if #(.WIDTH(16)) if16 ();

   alu_md_seq #(.WIDTH(32), .MD_EN(1'b1)) u_dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(if32));
   alu_md_seq #(.WIDTH(16), .MD_EN(1'b1)) u_dut16 (.clk(clk), .rst(rst), .flush(flush), .bus(if16));

   typedef struct {
      bit          w16;
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [2:0]  flg;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic get_ov(input bit w16);
      return w16 ? if16.out_valid : if32.out_valid;
   endfunction

   function automatic logic get_rdy(input bit w16);
      return w16 ? if16.in_ready : if32.in_ready;
   endfunction

   function automatic logic [31:0] get_res(input bit w16);
      return w16 ? {16'h0, if16.result} : if32.result;
   endfunction

   function automatic logic [2:0] get_flg(input bit w16);
      return w16 ? {if16.overflow, if16.carry_out, if16.zero}
                 : {if32.overflow, if32.carry_out, if32.zero};
   endfunction

   task automatic drive(input bit w16, input logic vld, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic ordy);
      if (w16) begin
         if16.in_valid = vld; if16.alu_op = op; if16.a = a[15:0]; if16.b = b[15:0];
         if16.out_ready = ordy;
      end else begin
         if32.in_valid = vld; if32.alu_op = op; if32.a = a; if32.b = b;
         if32.out_ready = ordy;
      end
   endtask

   // Presents one op at a falling edge and returns once out_valid is seen (bounded).
   task automatic run_op(input bit w16, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic ordy,
                         output logic [31:0] res, output logic [2:0] flg, output int lat);
      @(negedge clk);
      drive(w16, 1'b1, op, a, b, ordy);
      @(negedge clk);
      drive(w16, 1'b0, op, a, b, ordy);
      lat = 1;
      while (!get_ov(w16) && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check_eq("out_valid_seen", get_ov(w16), 1'b1);
      res = get_res(w16);
      flg = get_flg(w16);
   endtask

   initial begin
      logic [31:0] res;
      logic [2:0]  flg;
      int          lat;
      int          seen;

      drive(1'b0, 1'b0, OP_ADD, 32'h0, 32'h0, 1'b1);
      drive(1'b1, 1'b0, OP_ADD, 32'h0, 32'h0, 1'b1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("rst_outputs", {get_ov(0), get_rdy(0), get_res(0), get_flg(0)}, 64'h0);
      rst = 1'b0;
      #1;
      check_eq("rst_release_rdy", get_rdy(0), 1'b1);

      vecs.push_back('{1'b0, OP_ADD,    32'h7FFFFFFF, 32'h1,        32'h80000000, 3'b100, 1});
      vecs.push_back('{1'b0, OP_SUB,    32'h5,        32'h5,        32'h0,        3'b001, 1});
      vecs.push_back('{1'b0, OP_SLTU,   32'h1,        32'h2,        32'h1,        3'b000, 1});
      vecs.push_back('{1'b0, OP_SUB,    32'h0,        32'h1,        32'hFFFFFFFF, 3'b010, 1});
      vecs.push_back('{1'b0, OP_SLT,    32'hFFFFFFFF, 32'h1,        32'h1,        3'b000, 1});
      vecs.push_back('{1'b0, OP_SGE,    32'hFFFFFFFF, 32'h1,        32'h0,        3'b001, 1});
      vecs.push_back('{1'b0, OP_SRA,    32'h80000000, 32'h4,        32'hF8000000, 3'b000, 1});
      vecs.push_back('{1'b0, OP_SLL,    32'h1,        32'h21,       32'h2,        3'b000, 1});
      vecs.push_back('{1'b0, OP_NOR,    32'h0,        32'h0,        32'hFFFFFFFF, 3'b000, 1});
      vecs.push_back('{1'b0, OP_JLINK,  32'h100,      32'h7,        32'h104,      3'b000, 1});
      vecs.push_back('{1'b0, OP_BYPASS, 32'h0,        32'hABCD,     32'hABCD,     3'b000, 1});
      vecs.push_back('{1'b0, OP_UNDEF,  32'h5,        32'h5,        32'h0,        3'b001, 1});
      vecs.push_back('{1'b0, OP_MUL,    32'hFFFFFFFD, 32'h7,        32'hFFFFFFEB, 3'b000, 33});
      vecs.push_back('{1'b0, OP_MULH,   32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 3'b000, 33});
      vecs.push_back('{1'b0, OP_MULHU,  32'hFFFFFFFF, 32'h2,        32'h1,        3'b000, 33});
      vecs.push_back('{1'b0, OP_DIV,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 3'b000, 33});
      vecs.push_back('{1'b0, OP_REM,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 3'b000, 33});
      vecs.push_back('{1'b0, OP_DIVU,   32'h9,        32'h0,        32'hFFFFFFFF, 3'b000, 33});
      vecs.push_back('{1'b0, OP_REMU,   32'h9,        32'h0,        32'h9,        3'b000, 33});
      vecs.push_back('{1'b0, OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 3'b000, 33});
      vecs.push_back('{1'b0, OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0,        3'b001, 33});
      vecs.push_back('{1'b1, OP_ADD,    32'h7FFF,     32'h1,        32'h8000,     3'b100, 1});
      vecs.push_back('{1'b1, OP_DIV,    32'hFFF9,     32'h2,        32'hFFFD,     3'b000, 17});
      vecs.push_back('{1'b1, OP_REM,    32'hFFF9,     32'h2,        32'hFFFF,     3'b000, 17});
      vecs.push_back('{1'b1, OP_DIV,    32'h8000,     32'hFFFF,     32'h8000,     3'b000, 17});
      vecs.push_back('{1'b1, OP_DIVU,   32'h9,        32'h0,        32'hFFFF,     3'b000, 17});

      foreach (vecs[i]) begin
         run_op(vecs[i].w16, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, res, flg, lat);
         check_eq($sformatf("v%0d_res", i), res, vecs[i].res);
         check_eq($sformatf("v%0d_flags", i), flg, vecs[i].flg);
         check_eq($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      end

      // Result must sit still in DONE while the consumer stalls.
      run_op(1'b0, OP_DIV, 32'd100, 32'd7, 1'b0, res, flg, lat);
      check_eq("bp_res", res, 32'd14);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check_eq($sformatf("bp_hold%0d", k), {get_ov(0), get_rdy(0), get_res(0)}, {2'b10, 32'd14});
      end
      if32.out_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_release", {get_ov(0), get_rdy(0)}, 2'b01);

      @(negedge clk);
      drive(1'b0, 1'b1, OP_DIV, 32'd100, 32'd7, 1'b1);
      @(negedge clk);
      drive(1'b0, 1'b0, OP_DIV, 32'd100, 32'd7, 1'b1);
      repeat (6) @(negedge clk);
      check_eq("flush_busy_rdy", get_rdy(0), 1'b0);
      flush = 1'b1;
      drive(1'b0, 1'b1, OP_ADD, 32'd1, 32'd1, 1'b1);
      @(negedge clk);
      flush = 1'b0;
      drive(1'b0, 1'b0, OP_ADD, 32'd1, 32'd1, 1'b1);
      check_eq("flush_idle", {get_ov(0), get_rdy(0)}, 2'b01);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (get_ov(0)) seen++;
      end
      check_eq("flush_no_result", seen, 0);
      run_op(1'b0, OP_ADD, 32'd2, 32'd3, 1'b1, res, flg, lat);
      check_eq("flush_after_res", res, 32'd5);

      @(negedge clk);
      drive(1'b0, 1'b1, OP_DIV, 32'd100, 32'd7, 1'b1);
      @(negedge clk);
      drive(1'b0, 1'b0, OP_DIV, 32'd100, 32'd7, 1'b1);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("rst_mid_busy", {get_ov(0), get_rdy(0), get_res(0), get_flg(0)}, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("rst_mid_release_rdy", get_rdy(0), 1'b1);
      run_op(1'b0, OP_DIV, 32'd100, 32'd7, 1'b1, res, flg, lat);
      check_eq("rst_after_res", res, 32'd14);
      check_eq("rst_after_latency", lat, 33);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
